reaction_timer_mp: RTL and testbench

- Multi-player reaction-time game engine, the parametrised successor of the single-player SET/GO/SCORE controller.
- Arms on a start press and waits a pseudo-random delay of whole milliseconds, then lights GO.
- Times each player's first press in ms, detects false starts, picks the round winner, and keeps a best-time record across rounds.
- Sits between the debounced button inputs and the LED and seven-segment display logic.

---
 rtl/rt_pkg.sv | 15 +
 rtl/rt_lfsr.sv | 22 ++
 rtl/reaction_timer_mp.sv | 185 ++++++++++++++++++
 tb/tb_reaction_timer_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package rt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int LFSR_W = 16;
    // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1 (maximal length)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/rt_lfsr.sv
// Free-running Fibonacci LFSR; a non-zero seed keeps it out of the all-zero lock-up state.
module rt_lfsr
    import rt_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction-time game: random arm delay, per-player ms timing,
// false-start detection, round winner and best-time record.
module reaction_timer_mp
    import rt_pkg::*;
#(
    parameter int                NUM_PLAYERS      = 2,
    parameter int                CLK_DIV          = 100000,
    parameter int                DELAY_MIN_MS     = 1000,
    parameter int                DELAY_RANGE_LOG2 = 11,
    parameter int                TIMEOUT_MS       = 9999,
    parameter int                TIME_W           = 14,
    parameter logic [LFSR_W-1:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_btn,
    input  logic [NUM_PLAYERS-1:0]          player_btn,
    output logic                            led_ready,
    output logic                            led_go,
    output state_t                          state_o,
    output logic [NUM_PLAYERS*TIME_W-1:0]   rt_ms,
    output logic [NUM_PLAYERS-1:0]          rt_valid,
    output logic [NUM_PLAYERS-1:0]          false_start,
    output logic [$clog2(NUM_PLAYERS):0]    winner,
    output logic [TIME_W-1:0]               best_ms,
    output logic                            best_valid,
    output logic                            done
);

    localparam int WIN_W = $clog2(NUM_PLAYERS) + 1;
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DLY_W = $clog2(DELAY_MIN_MS + (1 << DELAY_RANGE_LOG2) + 1);
    localparam logic [NUM_PLAYERS-1:0] ALL    = '1;
    localparam logic [WIN_W-1:0]       NO_WIN = '1;
    localparam logic [LFSR_W-1:0]      RANGE_MASK = LFSR_W'((1 << DELAY_RANGE_LOG2) - 1);

    state_t                                 state_q, state_d;
    logic                                   start_q;
    logic [NUM_PLAYERS-1:0]                 btn_q;
    logic [PRE_W-1:0]                       pre_q, pre_d;
    logic [DLY_W-1:0]                       dly_q, dly_d;
    logic [TIME_W-1:0]                      el_q, el_d;
    logic [NUM_PLAYERS-1:0][TIME_W-1:0]     rt_q, rt_d, rt_nx;
    logic [NUM_PLAYERS-1:0]                 val_q, val_d, val_nx, fs_q, fs_d, cap;
    logic [WIN_W-1:0]                       win_q, win_d, win_c;
    logic [TIME_W-1:0]                      best_q, best_d, min_c;
    logic                                   bv_q, bv_d, done_q, done_d, found;
    logic                                   start_edge, tick, arm, fin;
    logic [NUM_PLAYERS-1:0]                 btn_edge;
    logic [LFSR_W-1:0]                      lfsr;

    rt_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr)
    );

    assign start_edge = start_btn & ~start_q;
    assign btn_edge   = player_btn & ~btn_q;
    assign tick       = (pre_q == PRE_W'(CLK_DIV - 1));

    // Captures take the pre-increment elapsed value, so a same-cycle tick is invisible.
    always_comb begin
        cap = '0;
        if (state_q == GO) cap = btn_edge & ~fs_q & ~val_q;
        val_nx = val_q | cap;
        rt_nx  = rt_q;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (cap[i]) rt_nx[i] = el_q;
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        found = 1'b0;
        win_c = NO_WIN;
        min_c = '1;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (val_nx[i] && (!found || rt_nx[i] < min_c)) begin
                found = 1'b1;
                win_c = WIN_W'(i);
                min_c = rt_nx[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = tick ? '0 : pre_q + PRE_W'(1);
        dly_d   = dly_q;
        el_d    = el_q;
        rt_d    = rt_q;
        val_d   = val_q;
        fs_d    = fs_q;
        win_d   = win_q;
        best_d  = best_q;
        bv_d    = bv_q;
        done_d  = 1'b0;
        arm     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: arm = start_edge;
            WAIT: begin
                fs_d = fs_q | btn_edge;
                if (tick && dly_q != '0) dly_d = dly_q - DLY_W'(1);
                if (fs_d == ALL) begin
                    fin = 1'b1;
                end else if (tick && dly_q == '0) begin
                    state_d = GO;
                    el_d    = '0;
                    pre_d   = '0;
                end
            end
            GO: begin
                rt_d  = rt_nx;
                val_d = val_nx;
                if (tick) el_d = el_q + TIME_W'(1);
                if ((fs_q | val_nx) == ALL || el_q == TIME_W'(TIMEOUT_MS)) fin = 1'b1;
            end
            DONE: arm = start_edge;
            default: ;
        endcase
        if (arm) begin
            state_d = WAIT;
            pre_d   = '0;
            dly_d   = DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr & RANGE_MASK);
            rt_d    = '0;
            val_d   = '0;
            fs_d    = '0;
            win_d   = NO_WIN;
        end
        if (fin) begin
            state_d = DONE;
            done_d  = 1'b1;
            win_d   = win_c;
            if (found && (!bv_q || min_c < best_q)) begin
                best_d = min_c;
                bv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            btn_q   <= '0;
            pre_q   <= '0;
            dly_q   <= '0;
            el_q    <= '0;
            rt_q    <= '0;
            val_q   <= '0;
            fs_q    <= '0;
            win_q   <= NO_WIN;
            best_q  <= '1;
            bv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_btn;
            btn_q   <= player_btn;
            pre_q   <= pre_d;
            dly_q   <= dly_d;
            el_q    <= el_d;
            rt_q    <= rt_d;
            val_q   <= val_d;
            fs_q    <= fs_d;
            win_q   <= win_d;
            best_q  <= best_d;
            bv_q    <= bv_d;
            done_q  <= done_d;
        end
    end

    assign state_o     = state_q;
    assign led_ready   = (state_q == WAIT);
    assign led_go      = (state_q == GO);
    assign rt_ms       = rt_q;
    assign rt_valid    = val_q;
    assign false_start = fs_q;
    assign winner      = win_q;
    assign best_ms     = best_q;
    assign best_valid  = bv_q;
    assign done        = done_q;

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Randomised rounds checked every cycle against a timing-arithmetic model of the game.
module tb_reaction_timer_mp;

    localparam int NP = 3, CD = 4, DMIN = 3, RL2 = 2, TO = 10, TW = 8;
    localparam int WW = $clog2(NP) + 1;
    localparam int RMAX = 120;
    localparam int NOWIN = (1 << WW) - 1;
    localparam int BEST_RST = (1 << TW) - 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [NP-1:0] ALL = '1;

    logic clk = 1'b0, rst_n = 1'b0, start_btn = 1'b0;
    logic [NP-1:0] player_btn = '0;
    logic led_ready, led_go, best_valid, done;
    logic [1:0] state_o;
    logic [NP*TW-1:0] rt_ms;
    logic [NP-1:0] rt_valid, false_start;
    logic [WW-1:0] winner;
    logic [TW-1:0] best_ms;

    always #5 clk = ~clk;

    reaction_timer_mp #(
        .NUM_PLAYERS(NP), .CLK_DIV(CD), .DELAY_MIN_MS(DMIN), .DELAY_RANGE_LOG2(RL2),
        .TIMEOUT_MS(TO), .TIME_W(TW), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .player_btn(player_btn),
        .led_ready(led_ready), .led_go(led_go), .state_o(state_o), .rt_ms(rt_ms),
        .rt_valid(rt_valid), .false_start(false_start), .winner(winner),
        .best_ms(best_ms), .best_valid(best_valid), .done(done)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Delay source as defined: 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    // Model: 0 idle, 1 wait, 2 go, 3 done
    int mst, mwin, mbest;
    int mrt[NP];
    logic [NP-1:0] mfs, mval;
    bit mbv, mdone;

    // Round plan: up to two presses per player plus an optional level held from before arming
    int s1[NP], l1[NP], s2[NP], l2[NP], hlen[NP];
    bit hold[NP], rel[NP];
    int spulse;

    function automatic bit lvl(int i, int r);
        return (hold[i] && r < hlen[i]) || (r >= s1[i] && r < s1[i] + l1[i]) ||
               (r >= s2[i] && r < s2[i] + l2[i]);
    endfunction

    task automatic reset_model();
        mst = 0; mwin = NOWIN; mbest = BEST_RST; mbv = 0; mdone = 0; mfs = '0; mval = '0;
        for (int i = 0; i < NP; i++) mrt[i] = 0;
    endtask

    task automatic check_all();
        logic [NP*TW-1:0] xr;
        for (int i = 0; i < NP; i++) xr[i*TW +: TW] = TW'(mrt[i]);
        chk("state", state_o, mst);
        chk("led_ready", led_ready, mst == 1);
        chk("led_go", led_go, mst == 2);
        chk("done", done, mdone);
        chk("false_start", false_start, mfs);
        chk("rt_valid", rt_valid, mval);
        chk("rt_ms", rt_ms, xr);
        chk("winner", winner, mwin);
        chk("best_ms", best_ms, mbest);
        chk("best_valid", best_valid, mbv);
    endtask

    task automatic finish_model();
        mst = 3; mdone = 1; mwin = NOWIN;
        for (int i = 0; i < NP; i++)
            if (mval[i] && (mwin == NOWIN || mrt[i] < mrt[mwin])) mwin = i;
        if (mwin != NOWIN && (!mbv || mrt[mwin] < mbest)) begin
            mbest = mrt[mwin];
            mbv = 1;
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NP; i++) begin
            hold[i] = 0; hlen[i] = 0; rel[i] = 0;
            s1[i] = 1000; l1[i] = 0; s2[i] = 1000; l2[i] = 0;
        end
        spulse = 60;
    endtask

    // rel=1: s is an offset from the GO-entry edge of this round
    task automatic setp(int i, int s, int l, bit r);
        s1[i] = s; l1[i] = l; rel[i] = r;
    endtask

    task automatic rand_plan();
        int k;
        clear_plan();
        for (int i = 0; i < NP; i++) begin
            k = $urandom_range(0, 9);
            if (k == 1) begin
                hold[i] = 1; hlen[i] = $urandom_range(5, 60);
            end else if (k != 0) begin
                s1[i] = (k >= 7) ? $urandom_range(1, 30) : $urandom_range(1, 70);
                rel[i] = (k >= 7);
                l1[i] = $urandom_range(1, 6);
                s2[i] = s1[i] + l1[i] + $urandom_range(1, 10);
                l2[i] = $urandom_range(1, 4);
            end
        end
        spulse = $urandom_range(5, 50);
    endtask

    task automatic run_round(int rst_at);
        int d, g, j, el, endr;
        bit [NP-1:0] e;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start_btn = 1'b0;
            for (int i = 0; i < NP; i++) player_btn[i] = hold[i];
        end
        @(negedge clk);
        d = DMIN + int'(m_lfsr[RL2-1:0]);
        for (int i = 0; i < NP; i++)
            if (rel[i]) begin
                s1[i] += (d + 1) * CD;
                s2[i] += (d + 1) * CD;
            end
        g = 0; endr = -1;
        for (int r = 0; r < RMAX; r++) begin
            if (r > 0) @(negedge clk);
            start_btn = (r < 3) || (mst != 3 && r >= spulse && r < spulse + 2);
            for (int i = 0; i < NP; i++) player_btn[i] = lvl(i, r);
            @(posedge clk);
            mdone = 0;
            if (r == 0) begin
                mst = 1; mfs = '0; mval = '0; mwin = NOWIN;
                for (int i = 0; i < NP; i++) mrt[i] = 0;
            end else begin
                for (int i = 0; i < NP; i++) e[i] = lvl(i, r) && !lvl(i, r - 1);
                if (mst == 1) begin
                    mfs |= e;
                    if (mfs == ALL) finish_model();
                    else if (r == (d + 1) * CD) begin
                        mst = 2; g = r;
                    end
                end else if (mst == 2) begin
                    j = r - g;
                    el = (j - 1) / CD;
                    for (int i = 0; i < NP; i++)
                        if (e[i] && !mfs[i] && !mval[i]) begin
                            mval[i] = 1'b1; mrt[i] = el;
                        end
                    if ((mfs | mval) == ALL || el == TO) finish_model();
                end
            end
            #1 check_all();
            if (r == rst_at) begin
                #2 rst_n = 1'b0;
                #1 reset_model();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (mst == 3 && endr < 0) endr = r;
            if (endr >= 0 && r >= endr + 2) break;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        check_all();

        // Tie at 4 ms between P0/P1, P2 later
        clear_plan(); setp(0, 17, 3, 1); setp(1, 17, 5, 1); setp(2, 25, 2, 1); run_round(-1);
        // P1/P2 false start, P0 at 3 ms ends the round at once
        clear_plan(); setp(0, 13, 2, 1); setp(1, 5, 3, 0); setp(2, 8, 2, 0); run_round(-1);
        // All false start
        clear_plan(); setp(0, 2, 2, 0); setp(1, 6, 1, 0); setp(2, 9, 4, 0); run_round(-1);
        // Timeout with no presses
        clear_plan(); run_round(-1);
        // P0 held from before arming: never captures
        clear_plan(); hold[0] = 1; hlen[0] = 70; setp(1, 9, 2, 1); setp(2, 26, 3, 1); run_round(-1);

        repeat (30) begin
            rand_plan();
            run_round(-1);
        end

        // Reset while in GO, then confirm the best record restarts
        clear_plan(); run_round(30);
        repeat (5) begin
            rand_plan();
            run_round(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
